// File: rtl/parallelizer_pkg.sv
// Shared widths, derived nibble/chunk counts and state encoding for the parallelizer.
// The key-chunk helper keeps chunk numbering (chunk 0 = most significant) in one place.
package parallelizer_pkg;

   localparam int NUM_ENCRYPTERS     = 4;
   localparam int ENCRYPTER_WIDTH    = 32;
   localparam int KEY_WIDTH          = 128;
   localparam int KEY_ROTATION_WIDTH = 32;

   localparam int KEY_QSPI_COUNT       = KEY_WIDTH / 4;
   localparam int ENCRYPTER_QSPI_COUNT = ENCRYPTER_WIDTH / 4;
   localparam int KEY_ENCRYPTER_COUNT  = KEY_WIDTH / KEY_ROTATION_WIDTH;

   localparam int KEY_QSPI_COUNT_REG       = $clog2(KEY_QSPI_COUNT + 1);
   localparam int ENCRYPTER_QSPI_COUNT_REG = $clog2(ENCRYPTER_QSPI_COUNT + 1);
   localparam int KEY_ENCRYPTER_COUNT_REG  = $clog2(KEY_ENCRYPTER_COUNT + 1);
   localparam int NUM_ENCRYPTERS_REG       = $clog2(NUM_ENCRYPTERS + 1);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_KEY_RX  = 3'd1,
      ST_KEY_TX  = 3'd2,
      ST_DATA_RX = 3'd3,
      ST_DATA_TX = 3'd4
   } state_t;

   function automatic logic [KEY_ROTATION_WIDTH-1:0] key_chunk(
      input logic [KEY_WIDTH-1:0]               key,
      input logic [KEY_ENCRYPTER_COUNT_REG-1:0] k
   );
      logic [KEY_WIDTH-1:0] shifted;
      shifted = key << (int'(k) * KEY_ROTATION_WIDTH);
      return shifted[KEY_WIDTH-1 -: KEY_ROTATION_WIDTH];
   endfunction

endpackage

// File: rtl/parallelizer_if.sv
// Nibble-source and encrypter-bank signals of the parallelizer, bundled with
// a slave view for the block itself and a master view for whoever drives it.
interface parallelizer_if;
   import parallelizer_pkg::*;

   logic [3:0]                    qspi_data;
   logic                          qspi_sending;
   logic                          qspi_ready;
   logic                          prog;
   logic [ENCRYPTER_WIDTH-1:0]    encrypters_data;
   logic [KEY_ROTATION_WIDTH-1:0] encrypters_key_rotation;
   logic [NUM_ENCRYPTERS-1:0]     encrypters_program;
   logic [NUM_ENCRYPTERS-1:0]     encrypters_data_ready;
   logic [NUM_ENCRYPTERS-1:0]     encrypters_ready;
   logic [2:0]                    state_out;

   modport slave (
      input  qspi_data, qspi_sending, prog, encrypters_ready,
      output qspi_ready, encrypters_data, encrypters_key_rotation,
             encrypters_program, encrypters_data_ready, state_out
   );

   modport master (
      output qspi_data, qspi_sending, prog, encrypters_ready,
      input  qspi_ready, encrypters_data, encrypters_key_rotation,
             encrypters_program, encrypters_data_ready, state_out
   );

endinterface

// File: rtl/parallelizer_nibble_shifter.sv
// MSB-first nibble accumulator: the first nibble of a word ends up in the top bits.
// done pulses combinationally on the shift that completes a word; the count then restarts.
module nibble_shifter #(
   parameter int W     = 32,
   parameter int COUNT = W / 4,
   parameter int CW    = $clog2(COUNT + 1)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clear,
   input  logic         shift_en,
   input  logic [3:0]   nibble,
   output logic [W-1:0] value,
   output logic         done
);

   localparam logic [CW-1:0] COUNT_LAST = CW'(COUNT - 1);

   logic [W-1:0]  value_q, value_d;
   logic [CW-1:0] count_q, count_d;

   always_comb begin
      value_d = value_q;
      count_d = count_q;
      done    = 1'b0;
      if (clear) begin
         value_d = '0;
         count_d = '0;
      end else if (shift_en) begin
         value_d = {value_q[W-5:0], nibble};
         if (count_q == COUNT_LAST) begin
            done    = 1'b1;
            count_d = '0;
         end else begin
            count_d = count_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value_q <= '0;
         count_q <= '0;
      end else begin
         value_q <= value_d;
         count_q <= count_d;
      end
   end

   assign value = value_q;

endmodule

// File: rtl/parallelizer.sv
// Collects a key and plaintext packets from a nibble stream, broadcasts the key in
// chunks to every encrypter and hands packets out round-robin, stalling on a busy core.
module parallelizer
   import parallelizer_pkg::*;
(
   input  logic          clk,
   input  logic          reset,
   parallelizer_if.slave bus
);

   localparam logic [NUM_ENCRYPTERS_REG-1:0]      IDX_LAST       = NUM_ENCRYPTERS_REG'(NUM_ENCRYPTERS - 1);
   localparam logic [KEY_ENCRYPTER_COUNT_REG-1:0] KEY_CHUNK_LAST = KEY_ENCRYPTER_COUNT_REG'(KEY_ENCRYPTER_COUNT);

   state_t                           state_q, state_d;
   logic [NUM_ENCRYPTERS_REG-1:0]      idx_q, idx_d;
   logic [KEY_ENCRYPTER_COUNT_REG-1:0] key_cnt_q, key_cnt_d;
   logic [KEY_ROTATION_WIDTH-1:0]      rotation_q, rotation_d;
   logic [NUM_ENCRYPTERS-1:0]          program_q, program_d;
   logic [ENCRYPTER_WIDTH-1:0]         data_q, data_d;
   logic [NUM_ENCRYPTERS-1:0]          data_ready_q, data_ready_d;

   logic                         qspi_ready;
   logic                         accept;
   logic                         key_shift_en, pkt_shift_en;
   logic                         key_done, pkt_done;
   logic [KEY_WIDTH-1:0]         key_value;
   logic [KEY_WIDTH-1:0]         key_with_last;
   logic [ENCRYPTER_WIDTH-1:0]   pkt_value;
   logic [NUM_ENCRYPTERS-1:0]    idx_onehot;
   logic                         target_ready;

   assign qspi_ready = (state_q == ST_IDLE) || (state_q == ST_KEY_RX) || (state_q == ST_DATA_RX);
   assign accept     = bus.qspi_sending && qspi_ready;

   // prog wins over a nibble arriving in the same cycle, so that nibble is dropped.
   assign key_shift_en = !bus.prog && accept && (state_q == ST_KEY_RX);
   assign pkt_shift_en = !bus.prog && accept && ((state_q == ST_IDLE) || (state_q == ST_DATA_RX));

   nibble_shifter #(
      .W     (KEY_WIDTH),
      .COUNT (KEY_QSPI_COUNT),
      .CW    (KEY_QSPI_COUNT_REG)
   ) u_key_shifter (
      .clk      (clk),
      .rst_n    (reset),
      .clear    (bus.prog),
      .shift_en (key_shift_en),
      .nibble   (bus.qspi_data),
      .value    (key_value),
      .done     (key_done)
   );

   nibble_shifter #(
      .W     (ENCRYPTER_WIDTH),
      .COUNT (ENCRYPTER_QSPI_COUNT),
      .CW    (ENCRYPTER_QSPI_COUNT_REG)
   ) u_pkt_shifter (
      .clk      (clk),
      .rst_n    (reset),
      .clear    (bus.prog),
      .shift_en (pkt_shift_en),
      .nibble   (bus.qspi_data),
      .value    (pkt_value),
      .done     (pkt_done)
   );

   // Chunk 0 must be on the bus in the first KEY_TX cycle, before the key register holds the last nibble.
   assign key_with_last = {key_value[KEY_WIDTH-5:0], bus.qspi_data};
   assign idx_onehot    = {{(NUM_ENCRYPTERS-1){1'b0}}, 1'b1} << idx_q;
   assign target_ready  = |(bus.encrypters_ready & idx_onehot);

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      key_cnt_d    = key_cnt_q;
      rotation_d   = rotation_q;
      program_d    = program_q;
      data_d       = data_q;
      data_ready_d = '0;
      if (bus.prog) begin
         state_d   = ST_KEY_RX;
         idx_d     = '0;
         key_cnt_d = '0;
         program_d = '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (pkt_done)          state_d = ST_DATA_TX;
               else if (pkt_shift_en) state_d = ST_DATA_RX;
            end
            ST_KEY_RX: begin
               if (key_done) begin
                  state_d    = ST_KEY_TX;
                  rotation_d = key_with_last[KEY_WIDTH-1 -: KEY_ROTATION_WIDTH];
                  program_d  = '1;
                  key_cnt_d  = KEY_ENCRYPTER_COUNT_REG'(1);
               end
            end
            // key_cnt_q is the index of the chunk to load next; at the count the broadcast ends.
            ST_KEY_TX: begin
               if (key_cnt_q == KEY_CHUNK_LAST) begin
                  state_d   = ST_IDLE;
                  program_d = '0;
                  key_cnt_d = '0;
               end else begin
                  rotation_d = key_chunk(key_value, key_cnt_q);
                  program_d  = '1;
                  key_cnt_d  = key_cnt_q + KEY_ENCRYPTER_COUNT_REG'(1);
               end
            end
            ST_DATA_RX: begin
               if (pkt_done) state_d = ST_DATA_TX;
            end
            ST_DATA_TX: begin
               if (target_ready) begin
                  data_d       = pkt_value;
                  data_ready_d = idx_onehot;
                  idx_d        = (idx_q == IDX_LAST) ? '0 : idx_q + NUM_ENCRYPTERS_REG'(1);
                  state_d      = ST_IDLE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         idx_q        <= '0;
         key_cnt_q    <= '0;
         rotation_q   <= '0;
         program_q    <= '0;
         data_q       <= '0;
         data_ready_q <= '0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         key_cnt_q    <= key_cnt_d;
         rotation_q   <= rotation_d;
         program_q    <= program_d;
         data_q       <= data_d;
         data_ready_q <= data_ready_d;
      end
   end

   assign bus.qspi_ready              = qspi_ready;
   assign bus.state_out               = state_q;
   assign bus.encrypters_data         = data_q;
   assign bus.encrypters_key_rotation = rotation_q;
   assign bus.encrypters_program      = program_q;
   assign bus.encrypters_data_ready   = data_ready_q;

endmodule

// File: tb/tb_parallelizer.sv
// Directed bench for parallelizer: reset, key broadcast, dispatch, round-robin wrap,
// back-pressure and abort, each checked against hand-computed values.
module tb_parallelizer;

   logic clk;
   logic reset;
   int   n_asrt;
   int   n_fail;

   parallelizer_if bus();

   parallelizer dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asrt++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_nib(input logic [3:0] n);
      bus.qspi_data    = n;
      bus.qspi_sending = 1'b1;
      tick();
      bus.qspi_sending = 1'b0;
   endtask

   task automatic send_pkt(input logic [31:0] w);
      for (int i = 7; i >= 0; i--) send_nib(w[i*4 +: 4]);
   endtask

   // Sends one full packet with all relevant encrypters ready and checks the strobe.
   task automatic dispatch(input string tag, input logic [31:0] w, input logic [3:0] exp_rdy);
      send_pkt(w);
      chk({tag, "_state_tx"}, 32'(bus.state_out), 32'd4);
      tick();
      chk({tag, "_rdy"}, 32'(bus.encrypters_data_ready), 32'(exp_rdy));
      chk({tag, "_data"}, bus.encrypters_data, w);
      chk({tag, "_state_idle"}, 32'(bus.state_out), 32'd0);
      tick();
      chk({tag, "_rdy_off"}, 32'(bus.encrypters_data_ready), 32'd0);
   endtask

   initial begin
      logic [3:0] nib;
      n_asrt = 0;
      n_fail = 0;
      reset = 1'b0;
      bus.qspi_data        = 4'h0;
      bus.qspi_sending     = 1'b0;
      bus.prog             = 1'b0;
      bus.encrypters_ready = 4'b1111;

      tick();
      tick();
      chk("rst_state", 32'(bus.state_out), 32'd0);
      chk("rst_qspi_ready", 32'(bus.qspi_ready), 32'd1);
      chk("rst_program", 32'(bus.encrypters_program), 32'd0);
      chk("rst_data_ready", 32'(bus.encrypters_data_ready), 32'd0);
      chk("rst_data", bus.encrypters_data, 32'd0);
      chk("rst_rotation", bus.encrypters_key_rotation, 32'd0);
      reset = 1'b1;
      tick();

      // Key load: 0..F twice, with a pause in the middle.
      bus.prog = 1'b1;
      tick();
      bus.prog = 1'b0;
      chk("key_rx_state", 32'(bus.state_out), 32'd1);
      for (int i = 0; i < 32; i++) begin
         if (i == 10) begin
            tick();
            tick();
            chk("key_pause_state", 32'(bus.state_out), 32'd1);
         end
         nib = 4'(i);
         send_nib(nib);
      end
      chk("key_tx_state0", 32'(bus.state_out), 32'd2);
      chk("key_tx_qspi_ready", 32'(bus.qspi_ready), 32'd0);
      chk("key_prog0", 32'(bus.encrypters_program), 32'hF);
      chk("key_rot0", bus.encrypters_key_rotation, 32'h01234567);
      tick();
      chk("key_tx_state1", 32'(bus.state_out), 32'd2);
      chk("key_prog1", 32'(bus.encrypters_program), 32'hF);
      chk("key_rot1", bus.encrypters_key_rotation, 32'h89ABCDEF);
      tick();
      chk("key_prog2", 32'(bus.encrypters_program), 32'hF);
      chk("key_rot2", bus.encrypters_key_rotation, 32'h01234567);
      tick();
      chk("key_tx_state3", 32'(bus.state_out), 32'd2);
      chk("key_prog3", 32'(bus.encrypters_program), 32'hF);
      chk("key_rot3", bus.encrypters_key_rotation, 32'h89ABCDEF);
      tick();
      chk("key_done_state", 32'(bus.state_out), 32'd0);
      chk("key_done_prog", 32'(bus.encrypters_program), 32'd0);
      chk("key_rot_hold", bus.encrypters_key_rotation, 32'h89ABCDEF);

      // Five packets with everyone ready: round-robin with wrap.
      dispatch("pkt0", 32'h12345678, 4'b0001);
      dispatch("pkt1", 32'hA1B2C3D4, 4'b0010);
      dispatch("pkt2", 32'h0F0F0F0F, 4'b0100);
      dispatch("pkt3", 32'hDEADBEEF, 4'b1000);
      dispatch("pkt4", 32'h55AA33CC, 4'b0001);
      chk("data_hold", bus.encrypters_data, 32'h55AA33CC);

      // Back-pressure on encrypter 1, which is next in line.
      bus.encrypters_ready = 4'b1101;
      send_pkt(32'h87654321);
      for (int i = 0; i < 3; i++) begin
         chk("bp_state", 32'(bus.state_out), 32'd4);
         chk("bp_qspi_ready", 32'(bus.qspi_ready), 32'd0);
         chk("bp_no_strobe", 32'(bus.encrypters_data_ready), 32'd0);
         tick();
      end
      chk("bp_data_unchanged", bus.encrypters_data, 32'h55AA33CC);
      bus.encrypters_ready = 4'b1111;
      tick();
      chk("bp_rdy", 32'(bus.encrypters_data_ready), 32'b0010);
      chk("bp_data", bus.encrypters_data, 32'h87654321);
      chk("bp_state_idle", 32'(bus.state_out), 32'd0);
      tick();
      chk("bp_rdy_off", 32'(bus.encrypters_data_ready), 32'd0);

      // Abort a partial packet with prog; the nibble in the prog cycle is dropped.
      send_nib(4'h9);
      send_nib(4'h9);
      send_nib(4'h9);
      chk("abort_rx_state", 32'(bus.state_out), 32'd3);
      bus.prog         = 1'b1;
      bus.qspi_data    = 4'h9;
      bus.qspi_sending = 1'b1;
      tick();
      bus.prog         = 1'b0;
      bus.qspi_sending = 1'b0;
      chk("abort_state", 32'(bus.state_out), 32'd1);
      chk("abort_no_strobe", 32'(bus.encrypters_data_ready), 32'd0);
      for (int i = 0; i < 32; i++) send_nib(4'hA);
      chk("abort_key_rot0", bus.encrypters_key_rotation, 32'hAAAAAAAA);
      for (int i = 0; i < 4; i++) tick();
      chk("abort_key_done", 32'(bus.state_out), 32'd0);
      for (int i = 0; i < 5; i++) send_nib(4'h3);
      chk("abort_partial_rx", 32'(bus.state_out), 32'd3);
      send_nib(4'h3);
      send_nib(4'h3);
      send_nib(4'h3);
      chk("abort_tx_state", 32'(bus.state_out), 32'd4);
      tick();
      chk("abort_rdy_idx0", 32'(bus.encrypters_data_ready), 32'b0001);
      chk("abort_data", bus.encrypters_data, 32'h33333333);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end

endmodule
